// File: rtl/gshare_ckpt_predictor.sv
// Gshare conditional-branch predictor with speculative global history and an in-order
// checkpoint FIFO that restores history exactly on mispredict or flush.
module gshare_ckpt_predictor #(
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned GHR_W      = 6,
  parameter int unsigned CKPT_DEPTH = 4,
  parameter int unsigned MISS_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            PL_stall,
  input  logic                            pred_valid,
  input  logic [31:0]                     pc,
  output logic                            pred_taken,
  output logic [CNT_W-1:0]                pred_count,
  output logic                            pred_ready,
  input  logic                            resolve_valid,
  input  logic                            resolve_taken,
  input  logic                            flush,
  output logic [$clog2(CKPT_DEPTH):0]     inflight,
  output logic [MISS_W-1:0]               miss_count
);

  localparam int unsigned TBL_N = 1 << IDX_W;
  localparam int unsigned PTR_W = $clog2(CKPT_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [GHR_W-1:0] ghr;
  } ckpt_t;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
  logic [OCC_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [GHR_W-1:0]  spec_ghr_q, spec_ghr_d;
  logic [GHR_W-1:0]  commit_ghr_q, commit_ghr_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              ready_q, ready_d;

  logic [CNT_W-1:0]  tbl_q [TBL_N];
  ckpt_t             fifo_q [CKPT_DEPTH];

  logic [OCC_W-1:0]  occ, occ_d;
  logic              run, fifo_empty, resolve, mispredict, accept, restore;
  ckpt_t             head, push_entry;
  logic [CNT_W-1:0]  head_cnt, train_cnt, tbl_wdata;
  logic [IDX_W-1:0]  rd_idx, tbl_waddr;
  logic              tbl_we;
  logic              unused_pc;

  assign unused_pc = ^{pc[31:IDX_W+2], pc[1:0]};

  // Resolution side: head of FIFO trains its own table entry.
  always_comb begin
    run        = (state_q == S_RUN);
    occ        = wr_ptr_q - rd_ptr_q;
    fifo_empty = (occ == '0);
    head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
    resolve    = run && resolve_valid && !fifo_empty;
    head_cnt   = tbl_q[head.idx];
    train_cnt  = head_cnt;
    if (resolve_taken) begin
      if (head_cnt != CNT_MAX) train_cnt = head_cnt + CNT_W'(1);
    end else begin
      if (head_cnt != '0) train_cnt = head_cnt - CNT_W'(1);
    end
    mispredict = resolve && (resolve_taken != head.taken);
  end

  // Prediction side, with bypass of a same-cycle training write.
  always_comb begin
    rd_idx     = pc[IDX_W+1:2] ^ IDX_W'(spec_ghr_q);
    pred_count = (resolve && (head.idx == rd_idx)) ? train_cnt : tbl_q[rd_idx];
    pred_taken = pred_count[CNT_W-1];
    accept     = pred_valid && ready_q && !PL_stall && !flush && !mispredict;
    push_entry = '{idx: rd_idx, taken: pred_taken, ghr: spec_ghr_q};
  end

  // Next-state for history, pointers, statistics and init sequencing.
  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    commit_ghr_d = commit_ghr_q;
    spec_ghr_d   = spec_ghr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    miss_d       = miss_q;
    restore      = run && (mispredict || flush);

    if (state_q == S_INIT) begin
      init_ptr_d = init_ptr_q + IDX_W'(1);
      if (init_ptr_q == {IDX_W{1'b1}}) state_d = S_RUN;
    end

    if (resolve) begin
      commit_ghr_d = {commit_ghr_q[GHR_W-2:0], resolve_taken};
      rd_ptr_d     = rd_ptr_q + OCC_W'(1);
    end

    if (mispredict) begin
      spec_ghr_d = {head.ghr[GHR_W-2:0], resolve_taken};
      if (miss_q != MISS_MAX) miss_d = miss_q + MISS_W'(1);
    end else if (restore) begin
      spec_ghr_d = commit_ghr_d;
    end else if (accept) begin
      spec_ghr_d = {spec_ghr_q[GHR_W-2:0], pred_taken};
    end

    if (restore) begin
      rd_ptr_d = wr_ptr_q;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + OCC_W'(1);
    end

    occ_d   = wr_ptr_d - rd_ptr_d;
    ready_d = (state_d == S_RUN) && (occ_d != OCC_W'(CKPT_DEPTH));
  end

  always_comb begin
    tbl_we    = (state_q == S_INIT) || resolve;
    tbl_waddr = (state_q == S_INIT) ? init_ptr_q : head.idx;
    tbl_wdata = (state_q == S_INIT) ? WEAK_NT : train_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_ptr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
      miss_q       <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
      miss_q       <= miss_d;
      ready_q      <= ready_d;
    end
  end

  // Storage arrays carry no reset; the init walk and FIFO pointers make their contents valid.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end

  assign pred_ready = ready_q;
  assign inflight   = occ;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_gshare_ckpt_predictor.sv
// Scoreboard bench for gshare_ckpt_predictor: expected values are queued with each stimulus
// step and compared against the DUT once the step's outputs are valid.
module tb_gshare_ckpt_predictor;

  localparam int unsigned CNT_W      = 2;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned GHR_W      = 6;
  localparam int unsigned CKPT_DEPTH = 4;
  localparam int unsigned MISS_W     = 16;
  localparam int unsigned INF_W      = $clog2(CKPT_DEPTH) + 1;

  localparam int S_CNT  = 0;
  localparam int S_TKN  = 1;
  localparam int S_RDY  = 2;
  localparam int S_INF  = 3;
  localparam int S_MISS = 4;
  localparam int S_SGHR = 5;
  localparam int S_CGHR = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              PL_stall = 1'b0;
  logic              pred_valid = 1'b0;
  logic [31:0]       pc = '0;
  logic              pred_taken;
  logic [CNT_W-1:0]  pred_count;
  logic              pred_ready;
  logic              resolve_valid = 1'b0;
  logic              resolve_taken = 1'b0;
  logic              flush = 1'b0;
  logic [INF_W-1:0]  inflight;
  logic [MISS_W-1:0] miss_count;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  int          sel_q[$];
  string       tag_q[$];
  logic [31:0] exp_q[$];

  gshare_ckpt_predictor #(
    .CNT_W(CNT_W), .IDX_W(IDX_W), .GHR_W(GHR_W), .CKPT_DEPTH(CKPT_DEPTH), .MISS_W(MISS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .pred_valid(pred_valid), .pc(pc),
    .pred_taken(pred_taken), .pred_count(pred_count), .pred_ready(pred_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .inflight(inflight), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] peek(input int sel);
    case (sel)
      S_CNT:   return 32'(pred_count);
      S_TKN:   return 32'(pred_taken);
      S_RDY:   return 32'(pred_ready);
      S_INF:   return 32'(inflight);
      S_MISS:  return 32'(miss_count);
      S_SGHR:  return 32'(dut.spec_ghr_q);
      S_CGHR:  return 32'(dut.commit_ghr_q);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic want(input int sel, input string tag, input logic [31:0] val);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic settle();
    #1;
    while (sel_q.size() > 0) begin
      int          s;
      string       t;
      logic [31:0] e;
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, peek(s), e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_of(input logic [7:0] pidx);
    return {22'b0, pidx, 2'b00};
  endfunction

  task automatic drive(input logic v, input logic [31:0] p, input logic rv,
                       input logic rt, input logic fl);
    pred_valid    = v;
    pc            = p;
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
  endtask

  // Release reset away from the clock edge and count edges until pred_ready rises.
  task automatic release_and_wait(input string tag);
    int cyc;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!pred_ready && cyc < 400);
    chk(tag, 32'(cyc), 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    want(S_RDY, "rst_ready", 0);
    want(S_INF, "rst_inflight", 0);
    want(S_MISS, "rst_miss", 0);
    want(S_SGHR, "rst_spec_ghr", 0);
    want(S_CGHR, "rst_commit_ghr", 0);
    settle();
    repeat (3) tick();
    release_and_wait("t1_ready_cycles");

    // Every entry starts weakly not-taken.
    for (int i = 0; i < 256; i++) begin
      drive(0, pc_of(8'(i)), 0, 0, 0);
      want(S_CNT, $sformatf("t1_cnt_%0d", i), 1);
      want(S_TKN, $sformatf("t1_tkn_%0d", i), 0);
      settle();
    end

    // Train idx 0x10 three times taken; history moves so the pc is adjusted each time.
    drive(1, pc_of(8'h10), 0, 0, 0);
    want(S_CNT, "t2_cnt0", 1); want(S_TKN, "t2_tkn0", 0); settle();
    tick(); want(S_INF, "t2_inf0", 1); want(S_SGHR, "t2_sghr0", 0); settle();
    drive(0, 0, 1, 1, 0); tick();
    want(S_INF, "t2_inf1", 0); want(S_MISS, "t2_miss1", 1);
    want(S_SGHR, "t2_sghr1", 6'h01); want(S_CGHR, "t2_cghr1", 6'h01); settle();
    drive(1, pc_of(8'h11), 0, 0, 0);
    want(S_CNT, "t2_cnt1", 2); want(S_TKN, "t2_tkn1", 1); settle();
    tick(); want(S_SGHR, "t2_sghr2", 6'h03); want(S_INF, "t2_inf2", 1); settle();
    drive(0, 0, 1, 1, 0); tick();
    want(S_MISS, "t2_miss2", 1); want(S_CGHR, "t2_cghr2", 6'h03);
    want(S_SGHR, "t2_sghr3", 6'h03); want(S_INF, "t2_inf3", 0); settle();
    drive(1, pc_of(8'h13), 0, 0, 0);
    want(S_CNT, "t2_cnt2", 3); want(S_TKN, "t2_tkn2", 1); settle();
    tick(); want(S_SGHR, "t2_sghr4", 6'h07); settle();
    drive(0, 0, 1, 1, 0); tick();
    want(S_CGHR, "t2_cghr3", 6'h07); want(S_MISS, "t2_miss3", 1); settle();
    drive(0, pc_of(8'h17), 0, 0, 0);
    want(S_CNT, "t2_cnt_sat", 3); settle();

    // Fill the FIFO with four not-taken predictions.
    for (int i = 0; i < 4; i++) begin
      drive(1, pc_of(8'h80), 0, 0, 0);
      want(S_TKN, $sformatf("t4_fill_tkn_%0d", i), 0); settle();
      tick();
    end
    want(S_INF, "t4_full_inf", 4); want(S_RDY, "t4_full_rdy", 0);
    want(S_SGHR, "t4_full_sghr", 6'h30); settle();
    tick();
    want(S_INF, "t4_hold_inf", 4); want(S_SGHR, "t4_hold_sghr", 6'h30); settle();
    drive(0, 0, 1, 0, 0);
    want(S_RDY, "t4_rdy_same_cycle", 0); settle();
    tick();
    want(S_INF, "t4_inf_after", 3); want(S_RDY, "t4_rdy_after", 1);
    want(S_CGHR, "t4_cghr", 6'h0E); want(S_MISS, "t4_miss", 1);
    want(S_SGHR, "t4_sghr", 6'h30); settle();

    // Head mispredict empties the FIFO and rebuilds history from its checkpoint.
    drive(0, 0, 1, 1, 0); tick();
    want(S_INF, "t3_inf", 0); want(S_SGHR, "t3_sghr", 6'h1D);
    want(S_CGHR, "t3_cghr", 6'h1D); want(S_MISS, "t3_miss", 2); want(S_RDY, "t3_rdy", 1); settle();
    drive(0, pc_of(8'h9A), 0, 0, 0); want(S_CNT, "t3_dec_entry", 0); settle();
    drive(0, pc_of(8'h93), 0, 0, 0); want(S_CNT, "t3_inc_entry", 2); settle();

    // Resolve with nothing in flight is ignored.
    drive(0, 0, 1, 1, 0); tick();
    want(S_CGHR, "empty_cghr", 6'h1D); want(S_MISS, "empty_miss", 2);
    want(S_INF, "empty_inf", 0); settle();

    // Flush with two in flight restores committed history; table untouched.
    drive(1, pc_of(8'hC0), 0, 0, 0); tick(); tick();
    want(S_INF, "t5_inf_pre", 2); want(S_SGHR, "t5_sghr_pre", 6'h34); settle();
    drive(0, 0, 0, 0, 1); tick();
    want(S_INF, "t5_inf", 0); want(S_SGHR, "t5_sghr", 6'h1D);
    want(S_CGHR, "t5_cghr", 6'h1D); want(S_MISS, "t5_miss", 2); settle();
    drive(0, pc_of(8'hC0), 0, 0, 0); want(S_CNT, "t5_tbl_dd", 1); settle();
    drive(0, pc_of(8'hE7), 0, 0, 0); want(S_CNT, "t5_tbl_fa", 1); settle();

    // Flush and mispredicting resolve in the same cycle.
    drive(1, pc_of(8'hC0), 0, 0, 0); tick();
    want(S_INF, "fr_inf_pre", 1); want(S_SGHR, "fr_sghr_pre", 6'h3A); settle();
    drive(0, 0, 1, 1, 1); tick();
    want(S_INF, "fr_inf", 0); want(S_CGHR, "fr_cghr", 6'h3B);
    want(S_SGHR, "fr_sghr", 6'h3B); want(S_MISS, "fr_miss", 3); settle();
    drive(0, pc_of(8'hE6), 0, 0, 0); want(S_CNT, "fr_tbl_dd", 2); settle();

    // Bypass: training write to idx 0x30 visible to the same-cycle read.
    drive(1, pc_of(8'h0B), 0, 0, 0); want(S_CNT, "t6_cnt0", 1); settle();
    tick(); want(S_SGHR, "t6_sghr0", 6'h36); want(S_INF, "t6_inf0", 1); settle();
    drive(1, pc_of(8'h06), 1, 1, 0);
    want(S_CNT, "t6_bypass_cnt", 2); want(S_TKN, "t6_bypass_tkn", 1); settle();
    tick();
    want(S_INF, "t6_inf1", 0); want(S_SGHR, "t6_sghr1", 6'h37);
    want(S_CGHR, "t6_cghr1", 6'h37); want(S_MISS, "t6_miss1", 4); settle();
    drive(1, pc_of(8'h07), 0, 0, 0);
    want(S_CNT, "t6_cnt2", 2); want(S_TKN, "t6_tkn2", 1); settle();
    tick(); want(S_SGHR, "t6_sghr2", 6'h2F); want(S_INF, "t6_inf2", 1); settle();
    drive(1, pc_of(8'h1F), 1, 1, 0);
    want(S_CNT, "t6_bypass2_cnt", 3); want(S_TKN, "t6_bypass2_tkn", 1); settle();
    tick();
    want(S_INF, "popush_inf", 1); want(S_SGHR, "popush_sghr", 6'h1F);
    want(S_CGHR, "popush_cghr", 6'h2F); want(S_MISS, "popush_miss", 4); settle();

    // Stall blocks enqueue but not resolution.
    PL_stall = 1'b1;
    drive(1, pc_of(8'h2F), 0, 0, 0); tick();
    want(S_INF, "stall_inf", 1); want(S_SGHR, "stall_sghr", 6'h1F); settle();
    drive(0, 0, 1, 1, 0); tick();
    want(S_INF, "stall_res_inf", 0); want(S_CGHR, "stall_res_cghr", 6'h1F);
    want(S_MISS, "stall_res_miss", 4); settle();
    PL_stall = 1'b0;

    // Reset mid-operation returns to INIT and re-clears the table.
    drive(1, pc_of(8'h40), 0, 0, 0); tick();
    want(S_INF, "mid_inf_pre", 1); settle();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    want(S_RDY, "mid_rst_rdy", 0); want(S_INF, "mid_rst_inf", 0);
    want(S_MISS, "mid_rst_miss", 0); want(S_SGHR, "mid_rst_sghr", 0); settle();
    repeat (2) tick();
    release_and_wait("mid_ready_cycles");
    drive(0, pc_of(8'h30), 0, 0, 0); want(S_CNT, "mid_tbl_30", 1); settle();
    drive(0, pc_of(8'h10), 0, 0, 0); want(S_CNT, "mid_tbl_10", 1); settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
